// File: rtl/cnt_down_timer.sv
// Two-digit BCD countdown timer with start/pause/resume control,
// one-cycle DONE pulse on expiry and a combinational zero/borrow flag.
module cnt_down_timer #(
  parameter int unsigned CNT_MAX_VAL = 9
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       TICK,
  input  logic       START,
  input  logic       PAUSE,
  input  logic       CLR,
  input  logic       LOAD,
  input  logic [7:0] DATA,
  output logic [7:0] CNTVAL,
  output logic       BUSY,
  output logic       DONE,
  output logic       BF
);

  localparam logic [3:0] MAXD = 4'(CNT_MAX_VAL);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] tens_q, tens_d;
  logic [3:0] units_q, units_d;
  logic       done_q, done_d;

  logic       is_zero;
  logic       is_one;
  logic [3:0] load_tens;
  logic [3:0] load_units;

  assign is_zero    = (tens_q == 4'd0) && (units_q == 4'd0);
  assign is_one     = (tens_q == 4'd0) && (units_q == 4'd1);
  assign load_tens  = (DATA[7:4] > MAXD) ? MAXD : DATA[7:4];
  assign load_units = (DATA[3:0] > MAXD) ? MAXD : DATA[3:0];

  // State, count and DONE registers with asynchronous active-low reset
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      tens_q  <= '0;
      units_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tens_q  <= tens_d;
      units_q <= units_d;
      done_q  <= done_d;
    end
  end

  // Next-state and count update; CLR > LOAD > START/PAUSE > TICK.
  // Any START or PAUSE pulse consumes the cycle, so a coincident TICK is dropped.
  always_comb begin
    state_d = state_q;
    tens_d  = tens_q;
    units_d = units_q;
    done_d  = 1'b0;
    if (CLR) begin
      state_d = IDLE;
      tens_d  = '0;
      units_d = '0;
    end else if (LOAD) begin
      state_d = IDLE;
      tens_d  = load_tens;
      units_d = load_units;
    end else if (START && PAUSE) begin
      state_d = state_q;
    end else if (START) begin
      if ((state_q == IDLE || state_q == PAUSED) && !is_zero) begin
        state_d = RUN;
      end
    end else if (PAUSE) begin
      if (state_q == RUN) begin
        state_d = PAUSED;
      end
    end else if (TICK && state_q == RUN && !is_zero) begin
      if (units_q == 4'd0) begin
        units_d = MAXD;
        tens_d  = tens_q - 4'd1;
      end else begin
        units_d = units_q - 4'd1;
      end
      if (is_one) begin
        state_d = EXPIRED;
        done_d  = 1'b1;
      end
    end
  end

  assign CNTVAL = {tens_q, units_q};
  assign BUSY   = (state_q == RUN);
  assign DONE   = done_q;
  assign BF     = is_zero;

endmodule

// File: tb/tb_cnt_down_timer.sv
// Scoreboard bench for cnt_down_timer: a decimal reference model pushes the
// expected outputs per driven cycle; they are popped and compared after the edge.
module tb_cnt_down_timer;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       TICK = 1'b0;
  logic       START = 1'b0;
  logic       PAUSE = 1'b0;
  logic       CLR = 1'b0;
  logic       LOAD = 1'b0;
  logic [7:0] DATA = '0;
  logic [7:0] CNTVAL;
  logic       BUSY;
  logic       DONE;
  logic       BF;

  cnt_down_timer #(.CNT_MAX_VAL(9)) dut (
    .CLK(CLK), .RST_N(RST_N), .TICK(TICK), .START(START), .PAUSE(PAUSE),
    .CLR(CLR), .LOAD(LOAD), .DATA(DATA), .CNTVAL(CNTVAL), .BUSY(BUSY),
    .DONE(DONE), .BF(BF)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] cnt;
    logic       busy;
    logic       done;
    logic       bf;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: count as a plain decimal integer
  int m_val  = 0;
  int m_st   = 0; // 0 idle, 1 run, 2 paused, 3 expired
  bit m_done = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.cnt  = {4'(m_val / 10), 4'(m_val % 10)};
    e.busy = (m_st == 1);
    e.done = m_done;
    e.bf   = (m_val == 0);
    return e;
  endfunction

  function automatic int clamp9(input logic [3:0] d);
    return (d > 4'd9) ? 9 : int'(d);
  endfunction

  task automatic model_step(input bit clr, input bit load, input bit start,
                            input bit pause, input bit tick, input logic [7:0] data);
    m_done = 0;
    if (clr) begin
      m_val = 0; m_st = 0;
    end else if (load) begin
      m_val = clamp9(data[7:4]) * 10 + clamp9(data[3:0]); m_st = 0;
    end else if (start && pause) begin
      // nothing
    end else if (start) begin
      if ((m_st == 0 || m_st == 2) && m_val != 0) m_st = 1;
    end else if (pause) begin
      if (m_st == 1) m_st = 2;
    end else if (tick && m_st == 1 && m_val > 0) begin
      m_val = m_val - 1;
      if (m_val == 0) begin
        m_st = 3; m_done = 1;
      end
    end
  endtask

  task automatic compare_pop(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    check({tag, "_cnt"},  32'(CNTVAL), 32'(e.cnt));
    check({tag, "_busy"}, 32'(BUSY),   32'(e.busy));
    check({tag, "_done"}, 32'(DONE),   32'(e.done));
    check({tag, "_bf"},   32'(BF),     32'(e.bf));
  endtask

  // one clock cycle of stimulus; called from posedge+1
  task automatic step(input string tag, input bit clr, input bit load, input bit start,
                      input bit pause, input bit tick, input logic [7:0] data);
    CLR = clr; LOAD = load; START = start; PAUSE = pause; TICK = tick; DATA = data;
    model_step(clr, load, start, pause, tick, data);
    exp_q.push_back(model_out());
    @(posedge CLK);
    #1;
    CLR = 0; LOAD = 0; START = 0; PAUSE = 0; TICK = 0;
    compare_pop(tag);
  endtask

  task automatic tick_n(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      step(tag, 0, 0, 0, 0, 1, 8'h00);
      step({tag, "_gap"}, 0, 0, 0, 0, 0, 8'h00);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    // reset held with TICK toggling
    RST_N = 0;
    for (int i = 0; i < 4; i++) begin
      TICK = ~TICK;
      @(posedge CLK);
      #1;
      exp_q.push_back(model_out());
      compare_pop("rst_hold");
    end
    TICK = 0;
    RST_N = 1;
    for (int i = 0; i < 3; i++) step("idle_tick", 0, 0, 0, 0, 1, 8'h00);

    // basic countdown from 12, borrow on third tick, DONE on reaching 00
    step("load12", 0, 1, 0, 0, 0, 8'h12);
    step("start12", 0, 0, 1, 0, 0, 8'h00);
    tick_n("cd", 12);
    step("cd_13th", 0, 0, 0, 0, 1, 8'h00);
    step("exp_start", 0, 0, 1, 0, 0, 8'h00);

    // pause / resume
    step("load05", 0, 1, 0, 0, 0, 8'h05);
    step("start05", 0, 0, 1, 0, 0, 8'h00);
    tick_n("pr_run", 2);
    step("pause_tick", 0, 0, 0, 1, 1, 8'h00);
    tick_n("pr_paused", 3);
    step("resume", 0, 0, 1, 0, 0, 8'h00);
    tick_n("pr_resumed", 3);

    // clamp and priority
    step("load_af", 0, 1, 0, 0, 0, 8'hAF);
    step("clr_load", 1, 1, 0, 0, 0, 8'h40);
    step("start_zero", 0, 0, 1, 0, 0, 8'h00);
    step("after_start_zero", 0, 0, 0, 0, 1, 8'h00);

    // abort and simultaneity
    step("load30", 0, 1, 0, 0, 0, 8'h30);
    step("start30", 0, 0, 1, 0, 0, 8'h00);
    step("tick30", 0, 0, 0, 0, 1, 8'h00);
    step("load07_tick", 0, 1, 0, 0, 1, 8'h07);
    step("start_pause", 0, 0, 1, 1, 0, 8'h00);
    step("start_tick", 0, 0, 1, 0, 1, 8'h00);
    step("tick07", 0, 0, 0, 0, 1, 8'h00);

    // asynchronous reset mid-run
    step("load50", 0, 1, 0, 0, 0, 8'h50);
    step("start50", 0, 0, 1, 0, 0, 8'h00);
    tick_n("r_run", 4);
    #2;
    RST_N = 0;
    #1;
    m_val = 0; m_st = 0; m_done = 0;
    exp_q.push_back(model_out());
    compare_pop("async_rst");
    @(negedge CLK);
    RST_N = 1;
    @(posedge CLK);
    #1;
    step("post_rst_tick", 0, 0, 0, 0, 1, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
